// File: rtl/tx_code_scheduler.sv
// tx_code_scheduler: round-robin arbiter in front of a single TX serializer.
// Grants one pending 8-bit code at a time, shifts it out MSB first with each
// bit held BIT_CYCLES clocks, then holds the channel idle for a guard gap.
module tx_code_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int BIT_CYCLES = 4,
  parameter int GUARD_BITS = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] code_in,
  output logic [NUM_REQ-1:0]   ack,
  output logic                 reject,
  output logic                 tx_bit,
  output logic                 tx_active,
  output logic                 busy
);

  localparam int PW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW   = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int GCYC = GUARD_BITS * BIT_CYCLES;
  localparam int GW   = (GCYC > 1) ? $clog2(GCYC) : 1;
  localparam logic [CW-1:0] CLAST = CW'(BIT_CYCLES - 1);
  localparam logic [GW-1:0] GLAST = GW'((GCYC > 0) ? GCYC - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GUARD} state_t;

  state_t               state_q;
  logic [PW-1:0]        ptr_q;
  logic [6:0]           sh_q;       // bits still to send after the one on tx_bit
  logic [CW-1:0]        cyc_q;
  logic [2:0]           bit_q;
  logic [GW-1:0]        gcnt_q;
  logic [NUM_REQ-1:0]   ack_q;
  logic                 reject_q;
  logic                 tx_bit_q;
  logic                 tx_active_q;
  logic                 busy_q;

  logic [NUM_REQ-1:0][7:0] codes_w;
  logic                    gnt_vld_d;
  logic [PW-1:0]           gnt_idx_d;
  logic [PW-1:0]           ptr_d;
  logic [7:0]              gnt_code_d;
  int                      j;

  assign codes_w = code_in;

  // Round-robin pick: first pending requester at or after the pointer, wrapping.
  always_comb begin
    gnt_vld_d = 1'b0;
    gnt_idx_d = '0;
    j         = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = int'(ptr_q) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (req[PW'(j)]) begin
        gnt_vld_d = 1'b1;
        gnt_idx_d = PW'(j);
      end
    end
    gnt_code_d = codes_w[gnt_idx_d];
    ptr_d      = (gnt_idx_d == PW'(NUM_REQ - 1)) ? '0 : gnt_idx_d + PW'(1);
  end

  // Grant / shift / guard FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      sh_q        <= '0;
      cyc_q       <= '0;
      bit_q       <= '0;
      gcnt_q      <= '0;
      ack_q       <= '0;
      reject_q    <= 1'b0;
      tx_bit_q    <= 1'b0;
      tx_active_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      ack_q    <= '0;
      reject_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (enable && gnt_vld_d) begin
            ack_q <= {{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_idx_d;
            ptr_q <= ptr_d;
            if (gnt_code_d[7]) begin
              state_q     <= S_SHIFT;
              sh_q        <= gnt_code_d[6:0];
              tx_bit_q    <= gnt_code_d[7];
              tx_active_q <= 1'b1;
              busy_q      <= 1'b1;
              cyc_q       <= '0;
              bit_q       <= '0;
            end else begin
              // Invalid code is dropped; the channel stays free.
              reject_q <= 1'b1;
            end
          end
        end
        S_SHIFT: begin
          if (cyc_q == CLAST) begin
            cyc_q <= '0;
            if (bit_q == 3'd7) begin
              tx_active_q <= 1'b0;
              tx_bit_q    <= 1'b0;
              if (GCYC == 0) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
              end else begin
                state_q <= S_GUARD;
                gcnt_q  <= '0;
              end
            end else begin
              bit_q    <= bit_q + 3'd1;
              tx_bit_q <= sh_q[6];
              sh_q     <= {sh_q[5:0], 1'b0};
            end
          end else begin
            cyc_q <= cyc_q + CW'(1);
          end
        end
        S_GUARD: begin
          if (gcnt_q == GLAST) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            gcnt_q <= gcnt_q + GW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ack       = ack_q;
  assign reject    = reject_q;
  assign tx_bit    = tx_bit_q;
  assign tx_active = tx_active_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_tx_code_scheduler.sv
// Bench for tx_code_scheduler: transaction-level model predicts each grant
// (who, which code, on which cycle); a negedge monitor pops and checks the
// ack/reject pulse and the serialized frame. A second small instance covers
// the single-cycle-bit, no-guard configuration.
module tb_tx_code_scheduler;
  localparam int NR = 4, BC = 4, GB = 2;
  localparam int FRAME = 8 * BC, GUARD = GB * BC;

  logic clk = 1'b0;
  logic rst = 1'b1, enable = 1'b0;
  logic [NR-1:0] req = '0;
  logic [NR-1:0][7:0] codes = '0;
  logic [8*NR-1:0] code_in;
  logic [NR-1:0] ack;
  logic reject, tx_bit, tx_active, busy;

  logic rst6 = 1'b1;
  logic [1:0] req6 = '0;
  logic [1:0][7:0] codes6 = '0;
  logic [15:0] code_in6;
  logic [1:0] ack6;
  logic rej6, txb6, txa6, busy6;

  assign code_in  = codes;
  assign code_in6 = codes6;

  tx_code_scheduler #(.NUM_REQ(NR), .BIT_CYCLES(BC), .GUARD_BITS(GB)) dut (
    .clk(clk), .rst(rst), .enable(enable), .req(req), .code_in(code_in),
    .ack(ack), .reject(reject), .tx_bit(tx_bit), .tx_active(tx_active), .busy(busy));

  tx_code_scheduler #(.NUM_REQ(2), .BIT_CYCLES(1), .GUARD_BITS(0)) dut6 (
    .clk(clk), .rst(rst6), .enable(1'b1), .req(req6), .code_in(code_in6),
    .ack(ack6), .reject(rej6), .tx_bit(txb6), .tx_active(txa6), .busy(busy6));

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int cyc = 0;
  int rst_edge = -1;
  bit rnd_on = 1'b0, hold_all = 1'b0;

  typedef struct { int idx; logic [7:0] code; bit valid; int cyc; } exp_t;
  exp_t q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, expv, cyc);
    end
  endtask

  // Reference model: one grant per free edge, channel busy for frame+guard.
  int ptr_m = 0, free_at = 0, g = 0, jm = 0;
  exp_t e_new;
  initial forever begin
    @(posedge clk);
    cyc++;
    if (rst) begin
      ptr_m = 0; free_at = cyc + 1; q.delete(); rst_edge = cyc;
    end else if (cyc >= free_at && enable && req != 0) begin
      g = -1;
      for (int k = 0; k < NR; k++) begin
        jm = (ptr_m + k) % NR;
        if (g < 0 && req[jm]) g = jm;
      end
      e_new.idx = g; e_new.code = codes[g]; e_new.valid = codes[g][7]; e_new.cyc = cyc;
      q.push_back(e_new);
      ptr_m = (g + 1) % NR;
      free_at = e_new.valid ? cyc + FRAME + GUARD + 1 : cyc + 1;
    end
  end

  // Monitor: pop expected grants when due, then follow the frame.
  int fpos = -1;
  logic [7:0] fc;
  exp_t e_got;
  initial forever begin
    @(negedge clk);
    if (rst_edge == cyc) begin
      chk("reset_outputs", 64'({ack, reject, tx_bit, tx_active, busy}), 64'd0);
      fpos = -1;
    end else begin
      if (q.size() > 0 && q[0].cyc <= cyc) begin
        e_got = q.pop_front();
        chk("ack_onehot", 64'(ack), 64'(1) << e_got.idx);
        chk("reject", 64'(reject), 64'(!e_got.valid));
        chk("ack_cycle", 64'(cyc), 64'(e_got.cyc));
        if (e_got.valid) begin fpos = 0; fc = e_got.code; end
      end else if (ack != 0 || reject) begin
        chk("spurious_ack", 64'({ack, reject}), 64'd0);
      end
      if (fpos >= 0) begin
        if (fpos < FRAME) chk("frame_bits", 64'({tx_active, busy, tx_bit}), 64'({2'b11, fc[7 - fpos / BC]}));
        else              chk("guard", 64'({tx_active, busy, tx_bit}), 64'(3'b010));
        fpos++;
        if (fpos == FRAME + GUARD) fpos = -1;
      end else begin
        chk("idle", 64'({tx_active, busy, tx_bit}), 64'd0);
      end
    end
  end

  // One stimulus cycle: requesters drop req on ack, random traffic if enabled.
  task automatic step();
    @(negedge clk);
    if (!hold_all) req = req & ~ack;
    if (rnd_on) begin
      rst = ($urandom_range(599) == 0);
      if ($urandom_range(63) == 0) enable = ~enable;
      for (int i = 0; i < NR; i++)
        if (!req[i] && !ack[i] && $urandom_range(7) == 0) begin
          codes[i] = {1'($urandom_range(3) != 0), 7'($urandom)};
          req[i] = 1'b1;
        end
    end
  endtask

  bit seen;
  logic [17:0] av, bv, yv;
  initial begin
    repeat (3) step();
    rst = 1'b0; enable = 1'b1;
    // 1: single valid code
    codes[0] = 8'hA5; req = 4'b0001;
    repeat (FRAME + GUARD + 5) step();
    // 2: all requesters held high, round-robin order and spacing
    codes = {8'h84, 8'h83, 8'h82, 8'h81}; req = 4'b1111; hold_all = 1'b1;
    repeat (5 * (FRAME + GUARD + 1) + 2) step();
    hold_all = 1'b0; req = '0;
    repeat (FRAME + GUARD + 5) step();
    // 3: invalid code rejected, next request served
    codes[1] = 8'h35; req = 4'b0010;
    step();
    codes[2] = 8'hC3; req = req | 4'b0100;
    repeat (FRAME + GUARD + 5) step();
    // 4: reset mid-frame, pointer back to 0
    codes[2] = 8'h9C; req = 4'b0100; seen = 1'b0;
    for (int n = 0; n < 100 && !seen; n++) begin step(); seen = ack[2]; end
    chk("t4_grant_seen", 64'(seen), 64'd1);
    repeat (4 * BC + 1) step();
    codes[0] = 8'hF0; codes[3] = 8'h8F; req = req | 4'b1001; rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (2 * (FRAME + GUARD + 1) + 5) step();
    // 5: enable dropped mid-frame
    codes[1] = 8'hB7; req = 4'b0010; seen = 1'b0;
    for (int n = 0; n < 100 && !seen; n++) begin step(); seen = ack[1]; end
    chk("t5_grant_seen", 64'(seen), 64'd1);
    repeat (2 * BC + 1) step();
    enable = 1'b0; codes[2] = 8'hE1; req = req | 4'b0100;
    repeat (80) step();
    enable = 1'b1;
    repeat (FRAME + GUARD + 5) step();
    // random traffic
    rnd_on = 1'b1;
    repeat (4000) step();
    rnd_on = 1'b0; rst = 1'b0; enable = 1'b1;
    repeat (150) step();
    // 6: BIT_CYCLES=1, GUARD_BITS=0 instance
    @(negedge clk);
    rst6 = 1'b0; codes6 = {8'h80, 8'hFF}; req6 = 2'b11;
    for (int s = 0; s < 18; s++) begin
      @(negedge clk);
      av[17 - s] = txa6; bv[17 - s] = txb6; yv[17 - s] = busy6;
      if (s == 0) chk("t6_ack0", 64'({rej6, ack6}), 64'(3'b001));
      if (s == 9) chk("t6_ack1", 64'({rej6, ack6}), 64'(3'b010));
      req6 = req6 & ~ack6;
    end
    chk("t6_active", 64'(av), 64'(18'b111111110_111111110));
    chk("t6_bits",   64'(bv), 64'(18'b111111110_100000000));
    chk("t6_busy",   64'(yv), 64'(18'b111111110_111111110));
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
